// File: rtl/stream_bram_pkg.sv
// Shared types and constants for the stream-to-BRAM writer.
package stream_bram_pkg;

  typedef enum logic [2:0] {
    POLL,
    RDWAIT,
    CHECK,
    STREAM,
    STATUS
  } state_t;

  localparam logic [31:0] MBOX_ADDR = 32'h0000_0000;
  localparam int unsigned START_BIT = 31;
  localparam int unsigned DONE_BIT  = 30;
  localparam int unsigned LEN_W     = 16;

  // Completion word written back into the mailbox: START cleared, DONE set, count in the low bits.
  function automatic logic [31:0] make_status(input logic [LEN_W-1:0] count);
    logic [31:0] s;
    s              = '0;
    s[DONE_BIT]    = 1'b1;
    s[LEN_W-1:0]   = count;
    return s;
  endfunction

endpackage

// File: rtl/stream_bram_writer.sv
// Writes one bounded burst of stream words into BRAM port B per mailbox arm from the PS,
// then reports the written count back through the mailbox word.
module stream_bram_writer
  import stream_bram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 2048,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] BRAM_addr,
  output logic        BRAM_clk,
  output logic [31:0] BRAM_din,
  input  logic [31:0] BRAM_dout,
  output logic        BRAM_en,
  output logic        BRAM_rst,
  output logic [3:0]  BRAM_we,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_MAX = (POLL_INTERVAL > RD_LATENCY) ? POLL_INTERVAL : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LATENCY - 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(DEPTH_WORDS - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [LEN_W-1:0]  r_idx, w_idx_nxt;

  logic              r_en, w_en_nxt;
  logic [3:0]        r_we, w_we_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [31:0]       r_din, w_din_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_ready;
  logic              w_hs;
  logic [LEN_W-1:0]  w_mbox_len;
  logic [31:0]       w_data_addr;
  logic              w_unused_dout;

  assign BRAM_clk  = clk;
  assign BRAM_rst  = rst;
  assign BRAM_en   = r_en;
  assign BRAM_we   = r_we;
  assign BRAM_addr = r_addr;
  assign BRAM_din  = r_din;
  assign busy      = r_busy;
  assign done      = r_done;

  // Stream acceptance is decoded so a beat can be taken in the same cycle it is offered.
  assign w_ready     = (r_state == STREAM) && (r_idx < r_len);
  assign s_ready     = w_ready;
  assign w_hs        = s_valid & w_ready;
  assign w_mbox_len  = BRAM_dout[LEN_W-1:0];
  assign w_data_addr = 32'(r_idx + LEN_W'(1)) << 2;

  // Mailbox bits between START and LEN carry no meaning for this block.
  assign w_unused_dout = ^BRAM_dout[START_BIT-1:LEN_W];

  // State, counter and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= POLL;
      r_cnt   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // BRAM port and status outputs, loaded with the action of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_we   <= 4'h0;
      r_addr <= '0;
      r_din  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_en   <= w_en_nxt;
      r_we   <= w_we_nxt;
      r_addr <= w_addr_nxt;
      r_din  <= w_din_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_en_nxt    = 1'b0;
    w_we_nxt    = 4'h0;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_done_nxt  = 1'b0;

    case (r_state)
      POLL: begin
        if (r_cnt == POLL_LAST) begin
          w_en_nxt    = 1'b1;
          w_addr_nxt  = MBOX_ADDR;
          w_cnt_nxt   = '0;
          w_state_nxt = RDWAIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RDWAIT: begin
        if (r_cnt == RD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      CHECK: begin
        if (BRAM_dout[START_BIT]) begin
          w_len_nxt   = (w_mbox_len > MAX_LEN) ? MAX_LEN : w_mbox_len;
          w_idx_nxt   = '0;
          w_state_nxt = (w_len_nxt == '0) ? STATUS : STREAM;
        end else begin
          w_state_nxt = POLL;
        end
      end

      STREAM: begin
        if (w_hs) begin
          w_en_nxt   = 1'b1;
          w_we_nxt   = 4'hF;
          w_addr_nxt = w_data_addr;
          w_din_nxt  = s_data;
          w_idx_nxt  = r_idx + LEN_W'(1);
          if (r_idx == r_len - LEN_W'(1)) begin
            w_state_nxt = STATUS;
          end
        end
      end

      STATUS: begin
        w_en_nxt    = 1'b1;
        w_we_nxt    = 4'hF;
        w_addr_nxt  = MBOX_ADDR;
        w_din_nxt   = make_status(r_idx);
        w_done_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = POLL;
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = POLL;
      end
    endcase

    w_busy_nxt = (w_state_nxt == STREAM) || (w_state_nxt == STATUS);
  end

endmodule

// File: tb/tb_stream_bram_writer.sv
// Directed bench for stream_bram_writer with a behavioural BRAM and a write scoreboard.
module tb_stream_bram_writer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PI     = 8;
  localparam int unsigned RL     = 1;
  localparam int          PERIOD = PI + RL + 2;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  stream_bram_writer #(
    .DEPTH_WORDS  (DEPTH),
    .POLL_INTERVAL(PI),
    .RD_LATENCY   (RL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .BRAM_addr(BRAM_addr),
    .BRAM_clk (BRAM_clk),
    .BRAM_din (BRAM_din),
    .BRAM_dout(BRAM_dout),
    .BRAM_en  (BRAM_en),
    .BRAM_rst (BRAM_rst),
    .BRAM_we  (BRAM_we),
    .busy     (busy),
    .done     (done)
  );

  // BRAM model: read-first, one-cycle read latency, plus a PS-side write path.
  logic [31:0]   mem [DEPTH];
  logic          ps_we;
  logic [AW-1:0] ps_addr;
  logic [31:0]   ps_wdata;

  always @(posedge clk) begin
    if (ps_we) mem[ps_addr] <= ps_wdata;
    if (BRAM_en) begin
      if (BRAM_we == 4'hF) mem[BRAM_addr[AW+1:2]] <= BRAM_din;
      BRAM_dout <= mem[BRAM_addr[AW+1:2]];
    end
  end

  int          n_cmp;
  int          n_mis;
  int          cyc;
  int          n_done;
  int          n_ready;
  int          n_reads;
  int          last_rd;
  bit          idle_chk;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watches the BRAM port every cycle; writes are popped against the scoreboard.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_ready === 1'b1) n_ready++;
      if (BRAM_en === 1'b1) begin
        n_cmp++;
        assert (BRAM_we === 4'h0 || BRAM_we === 4'hF) else begin
          n_mis++;
          $error("FAIL we_value observed=%h expected=0_or_F", BRAM_we);
        end
      end
      if (BRAM_en === 1'b1 && BRAM_we === 4'hF) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_mis++;
          $error("FAIL unexpected_write observed=%h/%h expected=none", BRAM_addr, BRAM_din);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          assert ({BRAM_addr, BRAM_din} === e) else begin
            n_mis++;
            $error("FAIL write addr/data observed=%h/%h expected=%h/%h",
                   BRAM_addr, BRAM_din, e[63:32], e[31:0]);
          end
        end
      end
      if (BRAM_en === 1'b1 && BRAM_we === 4'h0) begin
        n_reads++;
        n_cmp++;
        assert (BRAM_addr === 32'h0) else begin
          n_mis++;
          $error("FAIL read_addr observed=%h expected=00000000", BRAM_addr);
        end
        if (idle_chk && last_rd >= 0) begin
          n_cmp++;
          assert (cyc - last_rd === PERIOD) else begin
            n_mis++;
            $error("FAIL poll_period observed=%0d expected=%0d", cyc - last_rd, PERIOD);
          end
        end
        last_rd = cyc;
      end
      if (done === 1'b1 || (BRAM_en === 1'b1 && BRAM_we === 4'hF && BRAM_addr === 32'h0)) begin
        n_cmp++;
        assert ((done === 1'b1) && (BRAM_en === 1'b1) && (BRAM_we === 4'hF) && (BRAM_addr === 32'h0)) else begin
          n_mis++;
          $error("FAIL done_vs_status observed done=%b en=%b we=%h addr=%h expected=1/1/F/0",
                 done, BRAM_en, BRAM_we, BRAM_addr);
        end
        if (done === 1'b1) n_done++;
      end
    end
  endtask

  task automatic ps_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    ps_we = 1'b1; ps_addr = a; ps_wdata = d;
    @(negedge clk);
    ps_we = 1'b0;
  endtask

  function automatic logic [31:0] status_of(input int n);
    return {2'b01, 14'h0, 16'(n)};
  endfunction

  // Arms (optionally) a transfer, feeds it, and checks the resulting count and status.
  task automatic stream_burst(input bit arm, input logic [15:0] len_f, input bit gaps,
                              input logic [31:0] base);
    int exp_n, got, k, d0, first_hs, last_hs;
    exp_n = (int'(len_f) > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : int'(len_f);
    d0 = n_done;
    first_hs = -1; last_hs = -1;
    if (arm) ps_write('0, {1'b1, 15'h0, len_f});
    k = 0;
    while (s_ready !== 1'b1 && k < 4 * PERIOD) begin @(negedge clk); k++; end
    chk("ready_rise", 32'(s_ready), 32'h1);
    got = 0; k = 0;
    while (s_ready === 1'b1 && k < 4 * int'(DEPTH)) begin
      s_valid = gaps ? ~k[0] : 1'b1;
      s_data  = base + 32'(got);
      if (s_valid) begin
        exp_q.push_back({32'((got + 1) * 4), base + 32'(got)});
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        got++;
      end
      @(negedge clk);
      k++;
    end
    s_valid = 1'b0;
    exp_q.push_back({32'h0, status_of(exp_n)});
    chk("beats_accepted", 32'(got), 32'(exp_n));
    if (!gaps) chk("consecutive_beats", 32'(last_hs - first_hs), 32'(exp_n - 1));
    k = 0;
    while (done !== 1'b1 && k < 8) begin @(negedge clk); k++; end
    chk("done_pulse", 32'(done), 32'h1);
    @(negedge clk);
    chk("mailbox_status", mem[0], status_of(exp_n));
    chk("ready_after", 32'(s_ready), 32'h0);
    chk("busy_after", 32'(busy), 32'h0);
    chk("done_count", 32'(n_done - d0), 32'h1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int k, r0, d0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    ps_we = 1'b0; ps_addr = '0; ps_wdata = '0;
    n_cmp = 0; n_mis = 0; cyc = 0; n_done = 0; n_ready = 0; n_reads = 0;
    last_rd = -1; idle_chk = 1'b0;
    fork monitor(); join_none

    // Reset values, with the first arm preloaded while held in reset.
    ps_write('0, 32'h8000_0004);
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(BRAM_en), 32'h0);
    chk("rst_we", 32'(BRAM_we), 32'h0);
    chk("rst_addr", BRAM_addr, 32'h0);
    chk("rst_din", BRAM_din, 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("bram_rst", 32'(BRAM_rst), 32'h1);
    chk("bram_clk", 32'(BRAM_clk), 32'(clk));
    rst = 1'b0;

    // Normal transfer of words 1..4.
    stream_burst(1'b0, 16'd4, 1'b0, 32'h1);

    // Backpressure gaps.
    stream_burst(1'b1, 16'd3, 1'b1, 32'hA0);

    // Zero length from a fresh reset, with a bounded status latency.
    rst = 1'b1;
    ps_write('0, 32'h8000_0000);
    exp_q.push_back({32'h0, 32'h4000_0000});
    r0 = n_ready;
    rst = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 4 * PERIOD) begin @(negedge clk); k++; end
    chk("zero_len_done", 32'(done), 32'h1);
    chk("zero_len_latency_ok", 32'(k <= int'(PI + RL + 3)), 32'h1);
    @(negedge clk);
    chk("zero_len_mailbox", mem[0], 32'h4000_0000);
    chk("zero_len_no_ready", 32'(n_ready - r0), 32'h0);

    // Clamp: LEN=32 on a 16-word BRAM writes 15 words, last at address 60.
    stream_burst(1'b1, 16'h20, 1'b0, 32'h100);

    // Reset after 2 of 4 beats, then the same arm is picked up again.
    ps_write('0, 32'h8000_0004);
    k = 0;
    while (s_ready !== 1'b1 && k < 4 * PERIOD) begin @(negedge clk); k++; end
    chk("abort_ready_rise", 32'(s_ready), 32'h1);
    d0 = n_done;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hC0 + 32'(i);
      exp_q.push_back({32'((i + 1) * 4), 32'hC0 + 32'(i)});
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_en", 32'(BRAM_en), 32'h0);
    chk("abort_we", 32'(BRAM_we), 32'h0);
    chk("abort_ready", 32'(s_ready), 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_mailbox", mem[0], 32'h8000_0004);
    chk("abort_no_done", 32'(n_done - d0), 32'h0);
    rst = 1'b0;
    stream_burst(1'b0, 16'd4, 1'b0, 32'hD0);

    // Idle polling with START clear.
    ps_write('0, 32'h0);
    repeat (2) @(negedge clk);
    r0 = n_reads;
    last_rd = -1;
    idle_chk = 1'b1;
    repeat (200) @(negedge clk);
    idle_chk = 1'b0;
    chk("idle_read_count_ok",
        32'((n_reads - r0 >= 200 / PERIOD - 1) && (n_reads - r0 <= 200 / PERIOD + 1)), 32'h1);
    chk("idle_no_writes", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
